// File: rtl/instr_capture_pkg.sv
// Shared definitions for the instruction capture front end: opcode map,
// instruction word field positions, FSM state encoding and decode helpers.
package instr_pkg;

   localparam logic [3:0] OP_ADD      = 4'd0;
   localparam logic [3:0] OP_SUB      = 4'd1;
   localparam logic [3:0] OP_AND      = 4'd2;
   localparam logic [3:0] OP_OR       = 4'd3;
   localparam logic [3:0] OP_XOR      = 4'd4;
   localparam logic [3:0] OP_MOV      = 4'd5;
   localparam logic [3:0] OP_ADDI     = 4'd6;
   localparam logic [3:0] OP_SUBI     = 4'd7;
   localparam logic [3:0] OP_ANDI     = 4'd8;
   localparam logic [3:0] OP_ORI      = 4'd9;
   localparam logic [3:0] OP_LAST_IMM = 4'd10;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RC_MSB  = 11;
   localparam int RC_LSB  = 8;
   localparam int RA_MSB  = 7;
   localparam int RA_LSB  = 4;
   localparam int RB_MSB  = 3;
   localparam int RB_LSB  = 0;

   localparam int REG_ADDR_W = 5;
   localparam int IMM_W      = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CAPTURE   = 3'd1,
      EXECUTE   = 3'd2,
      WRITEBACK = 3'd3,
      HOLD      = 3'd4
   } state_t;

   // Immediate-form opcodes sit in one contiguous band above the register forms.
   function automatic logic isImmOp(input logic [3:0] op);
      return (op >= OP_ADDI) && (op <= OP_LAST_IMM);
   endfunction

   function automatic logic isIllegalOp(input logic [3:0] op);
      return op > OP_LAST_IMM;
   endfunction

   function automatic logic [REG_ADDR_W-1:0] zextAddr(input logic [3:0] field);
      return {1'b0, field};
   endfunction

   function automatic logic [IMM_W-1:0] zextImm(input logic [3:0] field);
      return {12'd0, field};
   endfunction

endpackage

// File: rtl/instr_capture_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// single-cycle press pulse on the accepted released-to-pressed transition.
module key_debouncer
   import instr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_released,
   output logic o_press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic             r_stable;
   logic             r_press;
   logic [CNT_W-1:0] r_count;

   // Any movement of the synchronized level restarts the stability window;
   // the accepted level only follows once the window has fully elapsed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_prev   <= 1'b1;
         r_stable <= 1'b1;
         r_press  <= 1'b0;
         r_count  <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_press <= 1'b0;
         if ((r_sync2 != r_prev) || (r_sync2 == r_stable)) begin
            r_count <= '0;
         end else if (r_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_press  <= r_stable & ~r_sync2;
            r_count  <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_released = r_stable;
   assign o_press    = r_press;

endmodule

// File: rtl/instr_capture.sv
// Issue stage for the switch-driven processor: one decoded issue per debounced
// key press. Define INSTR_COUNT_EN to add the 16-bit retired-instruction counter.
module instr_capture
   import instr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ALU_WAIT        = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_exec_n,
   input  logic        key_read_n,
   input  logic [15:0] sw,
   output logic [3:0]  codeop,
   output logic [4:0]  reg_a,
   output logic [4:0]  reg_b,
   output logic [4:0]  reg_c,
   output logic [15:0] imm,
   output logic        flag_imm,
   output logic        bank_we,
   output logic        illegal,
   output logic        busy
`ifdef INSTR_COUNT_EN
   ,
   output logic [15:0] retired
`endif
);

   localparam int WAIT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

   logic w_execPress;
   logic w_execReleased;
   logic w_readPress;
   logic w_readReleased;
   logic w_waitDone;
   logic [3:0] w_opcode;

   state_t              r_state;
   logic [WAIT_W-1:0]   r_waitCnt;
   logic [3:0]          r_codeop;
   logic [4:0]          r_regA;
   logic [4:0]          r_regB;
   logic [4:0]          r_regC;
   logic [15:0]         r_imm;
   logic                r_flagImm;
   logic                r_bankWe;
   logic                r_illegal;
`ifdef INSTR_COUNT_EN
   logic [15:0]         r_retired;
`endif

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_execDeb (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_key_n    (key_exec_n),
      .o_released (w_execReleased),
      .o_press    (w_execPress)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_readDeb (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_key_n    (key_read_n),
      .o_released (w_readReleased),
      .o_press    (w_readPress)
   );

   assign w_opcode   = sw[OPC_MSB:OPC_LSB];
   assign w_waitDone = (int'(r_waitCnt) + 1) >= ALU_WAIT;

   // Single issue sequencer; every decoded field is a register updated only on
   // the transition that consumes the switches, so later switch moves are inert.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_waitCnt <= '0;
         r_codeop  <= '0;
         r_regA    <= '0;
         r_regB    <= '0;
         r_regC    <= '0;
         r_imm     <= '0;
         r_flagImm <= 1'b0;
         r_bankWe  <= 1'b0;
         r_illegal <= 1'b0;
`ifdef INSTR_COUNT_EN
         r_retired <= '0;
`endif
      end else begin
         r_bankWe <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_execPress) begin
                  r_state <= CAPTURE;
               end else if (w_readPress) begin
                  r_regA    <= zextAddr(sw[RC_MSB:RC_LSB]);
                  r_regB    <= zextAddr(sw[RA_MSB:RA_LSB]);
                  r_flagImm <= 1'b0;
                  r_state   <= HOLD;
               end
            end
            CAPTURE: begin
               r_codeop <= w_opcode;
               r_regC   <= zextAddr(sw[RC_MSB:RC_LSB]);
               if (isIllegalOp(w_opcode)) begin
                  r_illegal <= 1'b1;
                  r_state   <= HOLD;
               end else begin
                  r_illegal <= 1'b0;
                  r_waitCnt <= '0;
                  r_regB    <= zextAddr(sw[RB_MSB:RB_LSB]);
                  r_state   <= EXECUTE;
                  if (isImmOp(w_opcode)) begin
                     r_imm     <= zextImm(sw[RA_MSB:RA_LSB]);
                     r_flagImm <= 1'b1;
                  end else begin
                     r_regA    <= zextAddr(sw[RA_MSB:RA_LSB]);
                     r_flagImm <= 1'b0;
                  end
               end
            end
            EXECUTE: begin
               if (w_waitDone) begin
                  r_bankWe <= 1'b1;
                  r_state  <= WRITEBACK;
               end else begin
                  r_waitCnt <= r_waitCnt + 1'b1;
               end
            end
            WRITEBACK: begin
`ifdef INSTR_COUNT_EN
               r_retired <= r_retired + 16'd1;
`endif
               r_state <= HOLD;
            end
            HOLD: begin
               if (w_execReleased && w_readReleased) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign codeop   = r_codeop;
   assign reg_a    = r_regA;
   assign reg_b    = r_regB;
   assign reg_c    = r_regC;
   assign imm      = r_imm;
   assign flag_imm = r_flagImm;
   assign bank_we  = r_bankWe;
   assign illegal  = r_illegal;
   assign busy     = (r_state != IDLE);
`ifdef INSTR_COUNT_EN
   assign retired  = r_retired;
`endif

endmodule
